spi_reg_target: RTL and testbench

SPI_REG_TARGET -- requirements
Module: spi_reg_target

---
 rtl/spi_reg_target.sv | 170 +++++++++++++++++
 tb/tb_spi_reg_target.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_target.sv
// spi_reg_target -- SPI target exposing a bank of 8-bit config (write/read-back)
// and status (read-only) registers over 16-bit frames:
//   bit15 W/nR (1 = write), bits14:8 address, bits7:0 data, MSB first.
// All four SPI modes; mode is latched when chip select falls.
//
// Optional build macro:
//   SPI_CFG_READBACK_EN  reads with A[6]=1 return config_regs[A[5:0]].
//
// Ports:
//   clk          system clock, rising edge
//   rstb         asynchronous active-low reset
//   ena          clock enable; low freezes edge detection and all state
//   mode[1:0]    {CPOL,CPHA}, synchronized
//   spi_cs_n     chip select, active-low, synchronized
//   spi_clk      SPI clock, synchronized
//   spi_mosi     serial data in, synchronized
//   spi_miso     serial data out, registered
//   config_regs  flattened config registers, reg i at [8i+7:8i]
//   status_regs  flattened status registers, same packing
module spi_reg_target #(
    parameter int unsigned NUM_CFG    = 8,
    parameter int unsigned NUM_STATUS = 8,
    parameter int unsigned REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   sclk_d, cs_d;
    logic [1:0]             mode_q;
    logic [4:0]             cnt;
    logic [REG_WIDTH-1:0]   rx, tx, hdr;
    logic                   ld_pend, wr_pend;
    logic [REG_WIDTH-1:0]   tx_nxt, rd_src;
    logic                   miso_nxt;

    logic rise, fall, cs_fall, samp, shft;

    assign rise    = spi_clk & ~sclk_d;
    assign fall    = ~spi_clk & sclk_d;
    // cs_d resets low so a chip select already low at reset release is not
    // mistaken for a new frame.
    assign cs_fall = cs_d & ~spi_cs_n;
    assign samp    = ena & ~spi_cs_n & (state != IDLE) &
                     ((mode_q[1] == mode_q[0]) ? rise : fall);
    assign shft    = ena & ~spi_cs_n & (state != IDLE) &
                     ((mode_q[1] == mode_q[0]) ? fall : rise);

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            state <= IDLE;
        else if (ena)
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (spi_cs_n) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (cs_fall)                 state_nxt = ADDR;
                ADDR: if (samp && cnt == 5'd7)     state_nxt = DATA;
                DATA: if (samp && cnt == 5'd15)    state_nxt = DONE;
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Read source, selected by the latched address
    always_comb begin
        rd_src = '0;
`ifdef SPI_CFG_READBACK_EN
        if (hdr[6]) begin
            for (int unsigned i = 0; i < NUM_CFG; i++)
                if (hdr[5:0] == 6'(i))
                    rd_src = config_regs[i*REG_WIDTH +: REG_WIDTH];
        end else begin
            for (int unsigned i = 0; i < NUM_STATUS; i++)
                if (hdr[5:0] == 6'(i))
                    rd_src = status_regs[i*REG_WIDTH +: REG_WIDTH];
        end
`else
        for (int unsigned i = 0; i < NUM_STATUS; i++)
            if (hdr[6:0] == 7'(i))
                rd_src = status_regs[i*REG_WIDTH +: REG_WIDTH];
`endif
    end

    // Output logic: next tx contents and next MISO bit. Write frames load
    // zero so MISO stays low without a separate qualifier.
    always_comb begin
        tx_nxt = tx;
        if (spi_cs_n)
            tx_nxt = '0;
        else if (ld_pend)
            tx_nxt = hdr[REG_WIDTH-1] ? '0 : rd_src;
        else if (shft && cnt >= 5'd9)
            tx_nxt = {tx[REG_WIDTH-2:0], 1'b0};
        miso_nxt = (state_nxt == DATA) ? tx_nxt[REG_WIDTH-1] : 1'b0;
    end

    // Datapath
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_d      <= 1'b0;
            cs_d        <= 1'b0;
            mode_q      <= '0;
            cnt         <= '0;
            rx          <= '0;
            tx          <= '0;
            hdr         <= '0;
            ld_pend     <= 1'b0;
            wr_pend     <= 1'b0;
            spi_miso    <= 1'b0;
            config_regs <= '0;
        end else if (ena) begin
            sclk_d   <= spi_clk;
            cs_d     <= spi_cs_n;
            tx       <= tx_nxt;
            spi_miso <= miso_nxt;
            if (cs_fall)
                mode_q <= mode;

            // A frame that completed its 16th sample edge commits even if
            // chip select rises in the same clock.
            if (wr_pend) begin
                wr_pend <= 1'b0;
                if (hdr[REG_WIDTH-1])
                    for (int unsigned i = 0; i < NUM_CFG; i++)
                        if (hdr[6:0] == 7'(i))
                            config_regs[i*REG_WIDTH +: REG_WIDTH] <= rx;
            end

            if (spi_cs_n) begin
                cnt     <= '0;
                rx      <= '0;
                hdr     <= '0;
                ld_pend <= 1'b0;
            end else begin
                ld_pend <= 1'b0;
                if (samp && cnt != 5'd16) begin
                    cnt <= cnt + 5'd1;
                    rx  <= {rx[REG_WIDTH-2:0], spi_mosi};
                    if (cnt == 5'd7) begin
                        hdr     <= {rx[REG_WIDTH-2:0], spi_mosi};
                        ld_pend <= 1'b1;
                    end
                    if (cnt == 5'd15)
                        wr_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target (default 8 config / 8 status registers).
module tb_spi_reg_target;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        spi_cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [63:0] config_regs;
    logic [63:0] status_regs = 64'h8877_66C4_3322_1100;

    int checks = 0;
    int failures = 0;
    logic [15:0] cap;

    spi_reg_target #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .config_regs (config_regs),
        .status_regs (status_regs)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input logic [1:0] m);
        mode    = m;
        spi_clk = m[1];
        wait_clk(4);
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(4);
    endtask

    // Clocks n bits of word; MISO seen at each sample edge lands in c[15-k].
    task automatic frame_bits(input logic [15:0] word, input int n, output logic [15:0] c);
        logic cpha;
        cpha = mode[0];
        c = '0;
        for (int k = 0; k < n; k++) begin
            if (!cpha) begin
                spi_mosi = word[15-k];
                wait_clk(4);
                c[15-k] = spi_miso;
                spi_clk = ~spi_clk;
                wait_clk(4);
                spi_clk = ~spi_clk;
            end else begin
                spi_clk = ~spi_clk;
                spi_mosi = word[15-k];
                wait_clk(4);
                c[15-k] = spi_miso;
                spi_clk = ~spi_clk;
                wait_clk(4);
            end
        end
    endtask

    task automatic full_frame(input logic [1:0] m, input logic [15:0] word, output logic [15:0] c);
        frame_start(m);
        frame_bits(word, 16, c);
        frame_end();
    endtask

    initial begin
        wait_clk(3);
        check_eq("reset_cfg", config_regs, 64'h0);
        check_eq("reset_miso", {63'h0, spi_miso}, 64'h0);
        rstb = 1'b1;
        wait_clk(3);

        full_frame(2'd0, 16'h8201, cap);
        check_eq("m0_write_cfg", config_regs, 64'h0000_0000_0001_0000);
        check_eq("m0_write_miso", {48'h0, cap}, 64'h0);

        full_frame(2'd3, 16'h0400, cap);
        check_eq("m3_read_status4", {48'h0, cap}, 64'h0000_0000_0000_00C4);

        frame_start(2'd1);
        frame_bits(16'h85A5, 12, cap);
        frame_end();
        check_eq("m1_abort_cfg", config_regs, 64'h0000_0000_0001_0000);
        full_frame(2'd1, 16'h85A5, cap);
        check_eq("m1_write_cfg", config_regs, 64'h0000_A500_0001_0000);

        full_frame(2'd2, 16'h90FF, cap);
        check_eq("m2_oob_write", config_regs, 64'h0000_A500_0001_0000);
        full_frame(2'd2, 16'h1000, cap);
        check_eq("m2_oob_read", {48'h0, cap}, 64'h0);

        full_frame(2'd0, 16'h0700, cap);
        check_eq("m0_read_status7", {48'h0, cap}, 64'h0000_0000_0000_0088);
        full_frame(2'd1, 16'h0100, cap);
        check_eq("m1_read_status1", {48'h0, cap}, 64'h0000_0000_0000_0011);

        full_frame(2'd0, 16'h803C, cap);
        check_eq("m0_write_reg0", config_regs, 64'h0000_A500_0001_003C);
        full_frame(2'd0, 16'h4000, cap);
`ifdef SPI_CFG_READBACK_EN
        check_eq("readback_0x40", {48'h0, cap}, 64'h0000_0000_0000_003C);
`else
        check_eq("readback_0x40", {48'h0, cap}, 64'h0);
`endif

        ena = 1'b0;
        full_frame(2'd0, 16'h8377, cap);
        ena = 1'b1;
        wait_clk(4);
        check_eq("ena_low_frozen", config_regs, 64'h0000_A500_0001_003C);

        frame_start(2'd0);
        frame_bits(16'h81AA, 10, cap);
        rstb = 1'b0;
        wait_clk(2);
        check_eq("midframe_rst_cfg", config_regs, 64'h0);
        check_eq("midframe_rst_miso", {63'h0, spi_miso}, 64'h0);
        rstb = 1'b1;
        frame_end();
        full_frame(2'd0, 16'h81AA, cap);
        check_eq("post_rst_write", config_regs, 64'h0000_0000_0000_AA00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
